register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-read-port, single-write-port register file for the miscv32 core.
- Generation two of the per-register-enable register file. It replaces the all-registers-parallel write/read arrays with:
  - an addressed write port,
  - NUM_RD_PORTS addressed read ports with write-through bypass,
  - a hard-wired zero register,
  - a busy scoreboard that decode uses to detect RAW hazards on in-flight writes.
- Sits between decode/issue and writeback.

Parameters:
- WORD_SIZE, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD_PORTS, 2, number of independent read ports, >= 1.
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rstL  input  1  asynchronous, active-low reset.
- wenableL  input  1  active-low write enable.
- waddr  input  ADDR_W  write register index.
- wdata  input  WORD_SIZE  write data.
- raddr  input  NUM_RD_PORTS x ADDR_W  read indices (unpacked array).
- rdata  output  NUM_RD_PORTS x WORD_SIZE  read data (unpacked array).
- rbusy  output  NUM_RD_PORTS  per port: addressed register has a pending write.
- issue_valid  input  1  decode issues an instruction writing issue_rd.
- issue_rd  input  ADDR_W  destination register being reserved.
- busy_vec  output  NUM_REGS  full scoreboard, bit n = register n pending.

Behaviour:
- Reset:
  - Asynchronous assertion (rstL=0) immediately clears all registers and all busy bits. Deassertion is synchronous to clk via the upstream reset synchroniser.
  - While in reset, rdata=0, rbusy=0 and busy_vec=0 for all ports.
- Write:
  - On posedge clk with wenableL=0 and waddr!=0, reg[waddr] <= wdata.
  - Writes to index 0 are discarded.
- Read:
  - Combinational.
  - rdata[p] = 0 if raddr[p]==0.
  - Otherwise, if wenableL=0 and waddr==raddr[p], rdata[p] = wdata (same-cycle bypass).
  - Otherwise rdata[p] = reg[raddr[p]].
  - All ports are independent; any number of ports may address the same register.
- Scoreboard:
  - Set: issue_valid=1 and issue_rd!=0 sets busy[issue_rd] at posedge.
  - Clear: wenableL=0 and waddr!=0 clears busy[waddr] at posedge.
  - Same register set and cleared in one cycle: set wins. The new producer is younger than the retiring one, so the bit stays 1.
  - Different registers: both actions apply.
  - Set on an already-busy register: stays 1. There is no counting; decode stalls on WAW.
  - Clear on a non-busy register: no effect, no error.
  - busy[0] is constant 0.
- rbusy:
  - rbusy[p] = busy[raddr[p]] AND NOT (wenableL=0 AND waddr==raddr[p]).
  - A register being written this cycle reads as not busy, consistent with the bypass.
  - rbusy[p] = 0 for raddr[p]==0.
- Latency:
  - Read: 0 cycles.
  - Write: visible through the array 1 cycle after the write edge, and the same cycle via bypass.
  - Scoreboard: set/clear visible 1 cycle after the edge.
- Reset mid-operation clears everything, including in-flight reservations. No writes are lost that were not already committed at an edge.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- Defined:
  - Adds output dbg_regs, NUM_REGS x WORD_SIZE (unpacked), a continuous, non-bypassed view of the register array. dbg_regs[0] = 0.
  - Used by benches and the simulation trace dumper to print the whole file each cycle.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset: hold rstL=0 for 3 cycles with wenableL=0, waddr=5, wdata=32'hDEADBEEF, then release -> rdata all 0; reg5 reads 0 before the first post-reset write edge; busy_vec=0.
- Write/read plus zero register:
  - Write 32'h12345678 to reg 7 and 32'hFFFFFFFF to reg 0.
  - Read raddr={7,0} next cycle -> rdata={32'h12345678, 32'h0}.
- Bypass: in one cycle, wenableL=0, waddr=3, wdata=32'hA5A5A5A5, raddr[0]=3 -> rdata[0]=32'hA5A5A5A5 in that same cycle, before the edge.
- Scoreboard:
  - issue_valid with issue_rd=9 -> busy_vec[9]=1 next cycle; raddr[1]=9 gives rbusy[1]=1.
  - Write reg 9 -> rbusy[1]=0 during the write cycle and busy_vec[9]=0 after.
- Set/clear collision: reg 4 busy; same cycle issue_rd=4 with issue_valid, plus wenableL=0, waddr=4, wdata=32'h00000011 -> reg4=32'h11 and busy_vec[4] stays 1.
- All ports same register: NUM_RD_PORTS=4, all raddr=31 after writing 32'hCAFEF00D -> every rdata=32'hCAFEF00D. With REGFILE_DEBUG_PORT_EN, dbg_regs[31] matches.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port, single-write-port register file with write-through bypass and busy scoreboard.
// Define REGFILE_DEBUG_PORT_EN to add the dbg_regs array view output.
module register_file_mp #(
    parameter int WORD_SIZE    = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rstL,
    input  logic                 wenableL,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr [NUM_RD_PORTS],
    output logic [WORD_SIZE-1:0] rdata [NUM_RD_PORTS],
    output logic [NUM_RD_PORTS-1:0] rbusy,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic [NUM_REGS-1:0]  busy_vec
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    output logic [WORD_SIZE-1:0] dbg_regs [NUM_REGS]
`endif
);
    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic                 wr;

    assign wr = !wenableL && waddr != '0;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        // a new reservation is younger than the retiring write, so set wins
        if (issue_valid && issue_rd != '0)
            busy_d[issue_rd] = 1'b1;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic byp;
        assign byp      = !wenableL && waddr == raddr[p];
        // the reset gate keeps the bypass from leaking wdata while held in reset
        assign rdata[p] = (!rstL || raddr[p] == '0) ? '0 : byp ? wdata : regs_q[raddr[p]];
        assign rbusy[p] = busy_q[raddr[p]] && !byp;
    end

    assign busy_vec = busy_q;

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_regs = regs_q;
`endif
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: table-driven bench with a reference model and expected-value queue for register_file_mp.
module tb_register_file_mp;
    localparam int NP = 4;

    typedef struct {
        logic            wen_n;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [NP-1:0][4:0] ra;
        logic            iv;
        logic [4:0]      ir;
        logic [31:0]     e_rd0;
        logic            e_rb0;
    } vec_t;

    typedef struct {
        logic [31:0]   rd [NP];
        logic [NP-1:0] rb;
        logic [31:0]   bv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstL = 1'b0;
    logic        wenableL = 1'b0;
    logic [4:0]  waddr = 5'd5;
    logic [31:0] wdata = 32'hDEADBEEF;
    logic [4:0]  raddr [NP];
    logic [31:0] rdata [NP];
    logic [NP-1:0] rbusy;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] busy_vec;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [31:0] dbg_regs [32];
`endif

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    exp_t        q [$];
    vec_t        vecs [19];
    int          n_checks = 0;
    int          n_fail = 0;

    register_file_mp #(.WORD_SIZE(32), .NUM_REGS(32), .NUM_RD_PORTS(NP)) dut (
        .clk(clk), .rstL(rstL), .wenableL(wenableL), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_vec(busy_vec)
`ifdef REGFILE_DEBUG_PORT_EN
        , .dbg_regs(dbg_regs)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen_n, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] r0, input logic [4:0] r1, input logic iv,
                                input logic [4:0] ir, input logic [31:0] erd, input logic erb);
        vec_t v;
        v.wen_n = wen_n; v.wa = wa; v.wd = wd; v.ra = {r1, r1, r1, r0};
        v.iv = iv; v.ir = ir; v.e_rd0 = erd; v.e_rb0 = erb;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        wenableL = v.wen_n; waddr = v.wa; wdata = v.wd;
        issue_valid = v.iv; issue_rd = v.ir;
        for (int p = 0; p < NP; p++) begin
            raddr[p] = v.ra[p];
            e.rd[p] = v.ra[p] == 0 ? 32'h0 : (!v.wen_n && v.wa == v.ra[p]) ? v.wd : m_regs[v.ra[p]];
            e.rb[p] = v.ra[p] != 0 && m_busy[v.ra[p]] && !(!v.wen_n && v.wa == v.ra[p]);
        end
        e.bv = m_busy;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("v%0d rdata%0d", idx, p), rdata[p], e.rd[p]);
            chk($sformatf("v%0d rbusy%0d", idx, p), {31'b0, rbusy[p]}, {31'b0, e.rb[p]});
        end
        chk($sformatf("v%0d busy_vec", idx), busy_vec, e.bv);
        chk($sformatf("v%0d table rdata0", idx), rdata[0], v.e_rd0);
        chk($sformatf("v%0d table rbusy0", idx), {31'b0, rbusy[0]}, {31'b0, v.e_rb0});
        @(posedge clk);
        if (!v.wen_n && v.wa != 0) begin
            m_regs[v.wa] = v.wd;
            m_busy[v.wa] = 1'b0;
        end
        if (v.iv && v.ir != 0) m_busy[v.ir] = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 7,  32'h12345678, 7,  7,  0, 0, 32'h12345678, 0);
        vecs[1]  = mk(0, 0,  32'hFFFFFFFF, 7,  0,  0, 0, 32'h12345678, 0);
        vecs[2]  = mk(1, 0,  32'h0,        7,  0,  0, 0, 32'h12345678, 0);
        vecs[3]  = mk(0, 3,  32'hA5A5A5A5, 3,  7,  0, 0, 32'hA5A5A5A5, 0);
        vecs[4]  = mk(1, 0,  32'h0,        3,  3,  1, 9, 32'hA5A5A5A5, 0);
        vecs[5]  = mk(1, 0,  32'h0,        9,  9,  0, 0, 32'h0,        1);
        vecs[6]  = mk(0, 9,  32'h99,       9,  9,  0, 0, 32'h99,       0);
        vecs[7]  = mk(1, 0,  32'h0,        9,  9,  0, 0, 32'h99,       0);
        vecs[8]  = mk(1, 0,  32'h0,        4,  4,  1, 4, 32'h0,        0);
        vecs[9]  = mk(0, 4,  32'h11,       4,  4,  1, 4, 32'h11,       0);
        vecs[10] = mk(1, 0,  32'h0,        4,  4,  0, 0, 32'h11,       1);
        vecs[11] = mk(0, 4,  32'h22,       5,  4,  1, 5, 32'h0,        0);
        vecs[12] = mk(1, 0,  32'h0,        5,  4,  0, 0, 32'h0,        1);
        vecs[13] = mk(0, 6,  32'h66,       5,  6,  1, 5, 32'h0,        1);
        vecs[14] = mk(1, 0,  32'h0,        5,  6,  0, 0, 32'h0,        1);
        vecs[15] = mk(0, 31, 32'hCAFEF00D, 31, 31, 0, 0, 32'hCAFEF00D, 0);
        vecs[16] = mk(1, 0,  32'h0,        31, 31, 0, 0, 32'hCAFEF00D, 0);
        vecs[17] = mk(1, 0,  32'h0,        0,  31, 1, 0, 32'h0,        0);
        vecs[18] = mk(1, 0,  32'h0,        0,  0,  0, 0, 32'h0,        0);

        model_clear();
        for (int p = 0; p < NP; p++) raddr[p] = 5'd5;
        repeat (3) begin
            @(negedge clk);
            chk("reset rdata0", rdata[0], 32'h0);
            chk("reset rbusy", {28'b0, rbusy}, 32'h0);
            chk("reset busy_vec", busy_vec, 32'h0);
        end
        @(posedge clk);
        #1;
        rstL = 1'b1;
        wenableL = 1'b1;
        @(negedge clk);
        for (int p = 0; p < NP; p++) chk($sformatf("post-reset reg5 port%0d", p), rdata[p], 32'h0);
        chk("post-reset busy_vec", busy_vec, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) step(vecs[i], i);

        wenableL = 1'b1; issue_valid = 1'b0;
        for (int p = 0; p < NP; p++) raddr[p] = 5'd7;
        @(negedge clk);
        chk("pre-reset reg7", rdata[0], m_regs[7]);
        chk("pre-reset busy_vec", busy_vec, m_busy);
`ifdef REGFILE_DEBUG_PORT_EN
        chk("dbg_regs31", dbg_regs[31], 32'hCAFEF00D);
        chk("dbg_regs0", dbg_regs[0], 32'h0);
`endif
        #1 rstL = 1'b0;
        #1;
        model_clear();
        chk("async reset rdata0", rdata[0], 32'h0);
        chk("async reset busy_vec", busy_vec, 32'h0);
        @(posedge clk);
        #1 rstL = 1'b1;
        @(negedge clk);
        chk("after mid reset reg7", rdata[0], m_regs[7]);
        chk("after mid reset busy_vec", busy_vec, m_busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
